// File: rtl/ultrasonic_ping_sequencer_if.sv
// Result handshake between the ping sequencer and its consumer.
// Master presents result/result_valid; slave answers with result_ready.
interface ultrasonic_ping_sequencer_if;
  logic [12:0] result;
  logic        result_valid;
  logic        result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/ultrasonic_ping_sequencer.sv
// Ultrasonic ping sequencer: burst, listen window, result handshake, dead time.
// Optional echo glitch filter enabled by defining ECHO_FILTER_EN.
module ultrasonic_ping_sequencer #(
  parameter int BURST_CYCLES = 40,
  parameter int TIMEOUT      = 8000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_echo_in,
  input  logic [12:0] i_echo_time,
  output logic        o_burst,
  output logic        o_capture_reset,
  output logic [12:0] o_timer,
  output logic        o_echo,
  output logic        o_busy,
  ultrasonic_ping_sequencer_if.master m_res
);

  localparam int CMAX = (BURST_CYCLES > GAP_CYCLES) ?
                        BURST_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [12:0]   TMO        = 13'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_LISTEN,
    S_REPORT,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [12:0]     r_timer;
  logic [12:0]     r_result;
  logic [1:0]      r_sync;
  logic            w_echo_c;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_start) w_next = S_BURST;
      S_BURST:
        if (r_cnt == BURST_LAST) w_next = S_LISTEN;
      S_LISTEN:
        if (i_echo_time != '0 || r_timer == TMO)
          w_next = S_REPORT;
      S_REPORT:
        if (m_res.result_ready) w_next = S_GAP;
      S_GAP:
        if (r_cnt == GAP_LAST) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state ||
          (r_state != S_BURST && r_state != S_GAP))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      // timer only runs while staying in LISTEN, saturating at all-ones
      if (w_next != S_LISTEN)
        r_timer <= '0;
      else if (r_state == S_LISTEN && r_timer != '1)
        r_timer <= r_timer + 13'd1;
      if (r_state == S_LISTEN && w_next == S_REPORT)
        r_result <= i_echo_time;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_sync <= '0;
    else
      r_sync <= {r_sync[0], i_echo_in};
  end

`ifdef ECHO_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;
  logic       w_filt;

  always_comb begin
    w_filt = r_filt;
    if (r_sync[1] & r_hist[0] & r_hist[1])
      w_filt = 1'b1;
    else if (!(r_sync[1] | r_hist[0] | r_hist[1]))
      w_filt = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist <= '0;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
      r_filt <= w_filt;
    end
  end

  assign w_echo_c = w_filt;
`else
  assign w_echo_c = r_sync[1];
`endif

  // gating outside LISTEN hides transducer ringing from the capture stage
  always_comb begin
    o_burst            = (r_state == S_BURST);
    o_capture_reset    = (r_state != S_LISTEN);
    o_timer            = r_timer;
    o_echo             = w_echo_c & (r_state == S_LISTEN);
    o_busy             = (r_state != S_IDLE);
    m_res.result       = r_result;
    m_res.result_valid = (r_state == S_REPORT);
  end

endmodule

// File: tb/tb_ultrasonic_ping_sequencer.sv
// Bench for ultrasonic_ping_sequencer with an echo capture stage model.
// Results go through a queue scoreboard checked by a separate monitor.
module tb_ultrasonic_ping_sequencer;

`ifdef ECHO_FILTER_EN
  localparam int LAT = 4;
  localparam int GLITCH_RES = 0;
`else
  localparam int LAT = 2;
  localparam int GLITCH_RES = 7;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        echo_in = 1'b0;
  logic [12:0] echo_time = '0;
  logic        cap_done = 1'b0;
  logic        burst;
  logic        capture_reset;
  logic [12:0] timer;
  logic        echo;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int mon_exp;

  ultrasonic_ping_sequencer_if rif();

  ultrasonic_ping_sequencer #(
    .BURST_CYCLES(4),
    .TIMEOUT(50),
    .GAP_CYCLES(3)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_start(start),
    .i_echo_in(echo_in),
    .i_echo_time(echo_time),
    .o_burst(burst),
    .o_capture_reset(capture_reset),
    .o_timer(timer),
    .o_echo(echo),
    .o_busy(busy),
    .m_res(rif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (capture_reset) begin
      echo_time <= '0;
      cap_done  <= 1'b0;
    end else if (echo && !cap_done) begin
      echo_time <= timer;
      cap_done  <= 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rif.result_valid && rif.result_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(rif.result), -1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("scoreboard_result", int'(rif.result), mon_exp);
      end
    end
  end

  task automatic wait_timer(input int t, input string nm);
    int k = 0;
    while (!(capture_reset == 1'b0 && int'(timer) == t) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk(nm, int'(timer), t);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!rif.result_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk(nm, 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk(nm, 1, 0);
  endtask

  task automatic ack();
    @(posedge clk);
    #1 rif.result_ready = 1'b1;
    @(posedge clk);
    #1 rif.result_ready = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_burst"}, int'(burst), 0);
    chk({nm, "_capreset"}, int'(capture_reset), 1);
    chk({nm, "_timer"}, int'(timer), 0);
    chk({nm, "_echo"}, int'(echo), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_valid"}, int'(rif.result_valid), 0);
    chk({nm, "_result"}, int'(rif.result), 0);
  endtask

  initial begin
    int last;
    rif.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // ping with echo at timer 20
    kick();
    chk("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      chk("burst_on", int'(burst), 1);
      chk("burst_capreset", int'(capture_reset), 1);
      @(negedge clk);
    end
    chk("burst_off", int'(burst), 0);
    chk("listen_capreset", int'(capture_reset), 0);
    chk("timer_first", int'(timer), 0);
    @(negedge clk);
    chk("timer_second", int'(timer), 1);
    wait_timer(20, "wait_t20");
    echo_in = 1'b1;
    exp_q.push_back(20 + LAT);
    wait_timer(20 + LAT - 1, "wait_pre_echo");
    chk("echo_before_latency", int'(echo), 0);
    @(negedge clk);
    chk("echo_after_latency", int'(echo), 1);
    wait_valid("valid_echo");
    for (int i = 0; i < 5; i++) begin
      chk("result_hold", int'(rif.result), 20 + LAT);
      chk("valid_hold", int'(rif.result_valid), 1);
      @(negedge clk);
    end
    ack();
    @(negedge clk);
    chk("valid_drop", int'(rif.result_valid), 0);
    chk("gap_busy", int'(busy), 1);
    chk("echo_gap", int'(echo), 0);
    repeat (2) @(negedge clk);
    chk("gap_last_busy", int'(busy), 1);
    @(negedge clk);
    chk("gap_to_idle", int'(busy), 0);
    chk("result_retained", int'(rif.result), 20 + LAT);
    echo_in = 1'b0;
    repeat (6) @(negedge clk);

    // reset in the middle of LISTEN
    kick();
    wait_timer(30, "wait_t30");
    chk("result_retained_listen", int'(rif.result), 20 + LAT);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    reset = 1'b0;
    @(negedge clk);

    // normal ping after reset
    kick();
    wait_timer(10, "wait_t10");
    echo_in = 1'b1;
    exp_q.push_back(10 + LAT);
    wait_valid("valid_post_reset");
    echo_in = 1'b0;
    ack();
    wait_idle("idle_post_reset");
    repeat (6) @(negedge clk);

    // no echo, timeout
    kick();
    exp_q.push_back(0);
    last = -1;
    for (int k = 0; k < 300 && !rif.result_valid; k++) begin
      if (!capture_reset) last = int'(timer);
      @(negedge clk);
    end
    chk("timeout_last_timer", last, 50);
    chk("timeout_valid", int'(rif.result_valid), 1);
    ack();
    wait_idle("idle_timeout");

    // echo high during burst and gap is gated off
    echo_in = 1'b1;
    kick();
    for (int i = 0; i < 4; i++) begin
      chk("echo_burst_gated", int'(echo), 0);
      if (i == 2) echo_in = 1'b0;
      @(negedge clk);
    end
    exp_q.push_back(0);
    wait_valid("valid_gating");
    ack();
    echo_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("echo_gap_gated", int'(echo), 0);
    wait_idle("idle_gating");
    for (int i = 0; i < 5; i++) begin
      chk("start_in_gap_ignored", int'(busy | burst), 0);
      chk("echo_idle_gated", int'(echo), 0);
      @(negedge clk);
    end
    echo_in = 1'b0;
    repeat (6) @(negedge clk);

    // 2-cycle glitch at timer 5
    kick();
    wait_timer(5, "wait_t5");
    echo_in = 1'b1;
    repeat (2) @(negedge clk);
    echo_in = 1'b0;
    exp_q.push_back(GLITCH_RES);
    wait_valid("valid_glitch");
    ack();
    wait_idle("idle_glitch");
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
